// File: rtl/newton_recip_iter.sv
// newton_recip_iter: iterative Newton-Raphson reciprocal, out_value ~= floor(2^OUT_W / b), with valid/ready on both sides.
// Define NEWTON_RECIP_EXACT_EN to append a correction pass (FIX1/FIX2) that makes the result exactly floor(2^OUT_W / b).
module newton_recip_iter #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 48,
  parameter int ITERS  = 6,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_value,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_dz,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int XW = OUT_W + 1;
  localparam int TW = DATA_W + OUT_W + 2;
  localparam int EW = OUT_W + 2;
  localparam int PW = XW + EW;
  localparam int SW = PW - OUT_W;
  localparam int LW = $clog2(DATA_W);

  localparam logic [XW-1:0] X_MAX = {1'b0, {OUT_W{1'b1}}};
  localparam logic [TW-1:0] TWO_S = TW'(1) << (OUT_W + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_NORM,
    S_SEED,
    S_MUL1,
    S_SUB,
    S_MUL2,
`ifdef NEWTON_RECIP_EXACT_EN
    S_FIX1,
    S_FIX2,
`endif
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LW-1:0]     lead_q;
  logic              dz_q;
  logic [XW-1:0]     x_q;
  logic [TW-1:0]     t_q;
  logic [EW-1:0]     e_q;
  logic [3:0]        k_q;

  logic              accept;
  logic              last_iter;
  logic [LW-1:0]     lead;
  logic [XW-1:0]     seed_x;
  logic [TW-1:0]     prod_t;
  logic [EW-1:0]     e_new;
  logic [PW-1:0]     prod_xe;
  logic [SW-1:0]     x_shift;
  logic [XW-1:0]     x_mul2;
  logic [OUT_W-1:0]  done_value;

`ifdef NEWTON_RECIP_EXACT_EN
  localparam int RW = DATA_W + OUT_W + 3;
  logic [RW-1:0] r_q;
  logic          fix_ok;
  assign fix_ok = !r_q[RW-1] && (r_q < RW'(b_q));
`endif

  assign in_ready  = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;
  assign last_iter = (k_q == 4'(ITERS - 1));

  always_comb begin
    lead = '0;
    for (int i = 0; i < DATA_W; i++)
      if (b_q[i]) lead = LW'(i);
  end

  // Seed is 2^(OUT_W-1-p); b*seed lands in [2^(OUT_W-1), 2^OUT_W), so the error starts below one half.
  always_comb begin
    seed_x  = XW'(1) << (OUT_W - 1 - int'(lead_q));
    prod_t  = TW'(b_q) * TW'(x_q);
    e_new   = (t_q >= TWO_S) ? '0 : EW'(TWO_S - t_q);
    prod_xe = PW'(x_q) * PW'(e_q);
    x_shift = prod_xe[PW-1:OUT_W];
    if (x_shift == '0)
      x_mul2 = XW'(1);
    else if (x_shift > SW'(X_MAX))
      x_mul2 = X_MAX;
    else
      x_mul2 = x_shift[XW-1:0];
  end

  always_comb begin
    done_value = '1;
    if (!dz_q) begin
`ifdef NEWTON_RECIP_EXACT_EN
      done_value = x_q[OUT_W] ? '1 : x_q[OUT_W-1:0];
`else
      done_value = x_mul2[OUT_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Zero divisors still pass through SEED so their result appears two cycles after accept.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_NORM;
      S_NORM: state_next = S_SEED;
      S_SEED: state_next = dz_q ? S_DONE : S_MUL1;
      S_MUL1: state_next = S_SUB;
      S_SUB:  state_next = S_MUL2;
`ifdef NEWTON_RECIP_EXACT_EN
      S_MUL2: state_next = last_iter ? S_FIX1 : S_MUL1;
      S_FIX1: state_next = S_FIX2;
      S_FIX2: if (fix_ok) state_next = S_DONE;
`else
      S_MUL2: state_next = last_iter ? S_DONE : S_MUL1;
`endif
      S_DONE: if (out_ready) state_next = accept ? S_NORM : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q       <= '0;
      tag_q     <= '0;
      lead_q    <= '0;
      dz_q      <= 1'b0;
      x_q       <= '0;
      t_q       <= '0;
      e_q       <= '0;
      k_q       <= '0;
      out_value <= '0;
      out_tag   <= '0;
      out_dz    <= 1'b0;
`ifdef NEWTON_RECIP_EXACT_EN
      r_q       <= '0;
`endif
    end else begin
      if (accept) begin
        b_q   <= in_data;
        tag_q <= in_tag;
      end
      case (state)
        S_NORM: begin
          lead_q <= lead;
          dz_q   <= (b_q == '0);
        end
        S_SEED: begin
          x_q <= seed_x;
          k_q <= '0;
        end
        S_MUL1: t_q <= prod_t;
        S_SUB:  e_q <= e_new;
        S_MUL2: begin
          x_q <= x_mul2;
          k_q <= k_q + 4'd1;
        end
`ifdef NEWTON_RECIP_EXACT_EN
        S_FIX1: r_q <= (RW'(1) << OUT_W) - RW'(b_q) * RW'(x_q);
        S_FIX2: begin
          if (r_q[RW-1]) begin
            x_q <= x_q - XW'(1);
            r_q <= r_q + RW'(b_q);
          end else if (!fix_ok) begin
            x_q <= x_q + XW'(1);
            r_q <= r_q - RW'(b_q);
          end
        end
`endif
        default: ;
      endcase
      if (state_next == S_DONE && state != S_DONE) begin
        out_value <= done_value;
        out_tag   <= tag_q;
        out_dz    <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_newton_recip_iter.sv
// tb_newton_recip_iter: directed and random checks of newton_recip_iter against an arithmetic reference model.
// Follows NEWTON_RECIP_EXACT_EN in the same way as the design (exact floor when defined).
module tb_newton_recip_iter;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 48;
  localparam int ITERS  = 6;
  localparam int TAG_W  = 8;
  localparam logic [63:0]  SAT    = 64'h0000_FFFF_FFFF_FFFF;
  localparam logic [127:0] SAT128 = {64'd0, SAT};
`ifdef NEWTON_RECIP_EXACT_EN
  localparam int LAT_LO = 4 + 3 * ITERS;
  localparam int LAT_HI = 6 + 3 * ITERS;
`else
  localparam int LAT_LO = 2 + 3 * ITERS;
  localparam int LAT_HI = 2 + 3 * ITERS;
`endif

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  out_value;
  logic [TAG_W-1:0]  out_tag;
  logic              out_dz;
  logic              out_valid;
  logic              out_ready;

  int checks;
  int errors;

  newton_recip_iter #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ITERS(ITERS), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
    .out_value(out_value), .out_tag(out_tag), .out_dz(out_dz),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ideal_recip(input logic [31:0] b);
    logic [63:0] q;
    if (b == 32'd0) return SAT;
    q = (64'd1 << OUT_W) / {32'd0, b};
    if (q > SAT) q = SAT;
    return q;
  endfunction

  // Newton on x(2 - b*x/2^48) with truncation approaches 2^48/b from below,
  // so even a power-of-two divisor can finish one LSB under the true quotient.
  function automatic logic [63:0] ref_model(input logic [31:0] b);
`ifdef NEWTON_RECIP_EXACT_EN
    return ideal_recip(b);
`else
    logic [127:0] x, t, e, p;
    int lead;
    if (b == 32'd0) return SAT;
    lead = 0;
    for (int i = 0; i < 32; i++) if (b[i]) lead = i;
    x = 128'd1 << (OUT_W - 1 - lead);
    for (int k = 0; k < ITERS; k++) begin
      t = {96'd0, b} * x;
      e = (t >= (128'd1 << (OUT_W + 1))) ? 128'd0 : (128'd1 << (OUT_W + 1)) - t;
      p = (x * e) >> OUT_W;
      if (p == 128'd0) p = 128'd1;
      else if (p > SAT128) p = SAT128;
      x = p;
    end
    return x[63:0];
`endif
  endfunction

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic send_input(input logic [31:0] b, input logic [7:0] tag);
    int n;
    @(negedge clk);
    in_data  = b;
    in_tag   = tag;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_output("in_ready timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input logic [31:0] b, input logic [7:0] tag, input int lat);
    logic [63:0] ideal;
    logic [63:0] diff;
    logic        lat_ok;
    ideal = ideal_recip(b);
    diff  = (ideal > {16'd0, out_value}) ? ideal - {16'd0, out_value} : {16'd0, out_value} - ideal;
    if (b == 32'd0) lat_ok = (lat == 2);
    else            lat_ok = (lat >= LAT_LO) && (lat <= LAT_HI);
    check_output($sformatf("out_valid b=0x%0h", b), {63'd0, out_valid}, 64'd1);
    check_output($sformatf("latency b=0x%0h lat=%0d", b, lat), {63'd0, lat_ok}, 64'd1);
    check_output($sformatf("value b=0x%0h", b), {16'd0, out_value}, ref_model(b));
    check_output($sformatf("error bound b=0x%0h diff=%0d", b, diff), {63'd0, (diff <= 64'd2)}, 64'd1);
    check_output($sformatf("tag b=0x%0h", b), {56'd0, out_tag}, {56'd0, tag});
    check_output($sformatf("dz b=0x%0h", b), {63'd0, out_dz}, {63'd0, (b == 32'd0)});
  endtask

  task automatic consume();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output("out_valid drops after handoff", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic apply_stimulus(input logic [31:0] b, input logic [7:0] tag);
    int lat;
    send_input(b, tag);
    wait_result(lat);
    check_result(b, tag, lat);
    consume();
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [31:0] rb;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset in_ready", {63'd0, in_ready}, 64'd0);
    check_output("reset out_valid", {63'd0, out_valid}, 64'd0);
    check_output("reset out_value", {16'd0, out_value}, 64'd0);
    check_output("reset out_tag", {56'd0, out_tag}, 64'd0);
    check_output("reset out_dz", {63'd0, out_dz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(32'h0000_0100, 8'h5A);
    apply_stimulus(32'h0000_0000, 8'h11);
    apply_stimulus(32'h0000_0001, 8'h22);
    apply_stimulus(32'hFFFF_FFFF, 8'h23);
    apply_stimulus(32'd3, 8'h24);
    apply_stimulus(32'd7, 8'h25);
    apply_stimulus(32'd1000, 8'h26);
    apply_stimulus(32'h8000_0001, 8'h27);
    apply_stimulus(32'h8000_0000, 8'h28);
    apply_stimulus(32'd2, 8'h29);

    // Back-pressure: result held, new request refused, then handoff and accept on one edge.
    send_input(32'd7, 8'h33);
    wait_result(lat);
    check_result(32'd7, 8'h33, lat);
    @(negedge clk);
    in_data  = 32'd1000;
    in_tag   = 8'h44;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_output("hold out_value", {16'd0, out_value}, ref_model(32'd7));
      check_output("hold out_valid", {63'd0, out_valid}, 64'd1);
      check_output("hold in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check_output("same-edge in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_output("handoff out_valid", {63'd0, out_valid}, 64'd0);
    wait_result(lat);
    check_result(32'd1000, 8'h44, lat);
    consume();

    // Abort at MUL2 of the third iteration.
    send_input(32'd12345, 8'h66);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort out_valid", {63'd0, out_valid}, 64'd0);
    check_output("abort in_ready", {63'd0, in_ready}, 64'd0);
    check_output("abort out_value", {16'd0, out_value}, 64'd0);
    check_output("abort out_tag", {56'd0, out_tag}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_output("no output after abort", {63'd0, seen}, 64'd0);
    apply_stimulus(32'd5, 8'h77);

    for (int n = 0; n < 1500; n++) begin
      rb = $urandom >> $urandom_range(0, 31);
      apply_stimulus(rb, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
